// File: rtl/general_register_file_pkg.sv
// Shared types and helpers for the general register file: sweep FSM states
// and the per-byte merge used by both the write path and the read bypass.
package general_register_file_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/register_sweep_ctrl.sv
// Sweep sequencer: captures the fill value and walks an index across every
// register, one per cycle, then pulses done. Its write request outranks the
// external write port.
module register_sweep_ctrl
    import general_register_file_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 28,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr_req,
    input  logic [WIDTH-1:0] i_clr_data,
    output logic             o_sweep_we,
    output logic [IDX_W-1:0] o_sweep_idx,
    output logic [WIDTH-1:0] o_sweep_data,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    sweep_state_e     r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_done, w_done_nxt;

    // State, index, captured fill value and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; requests arriving while busy are dropped, not queued
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = '0;
                    w_data_nxt  = i_clr_data;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_sweep_we   = (r_state == ST_SWEEP);
    assign o_sweep_idx  = r_idx;
    assign o_sweep_data = r_data;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;

endmodule

// File: rtl/general_register_file.sv
// WIDTH x DEPTH register file: one byte-enabled write port, NREAD combinational
// read ports with optional write bypass, and a hardware fill sweep.
module general_register_file
    import general_register_file_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 28,
    parameter int SEL_W  = 6,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [WIDTH/8-1:0]     in_be,
    input  logic [NREAD*SEL_W-1:0] out_sel,
    output logic [NREAD*WIDTH-1:0] out,
    input  logic                   clr_req,
    input  logic [WIDTH-1:0]       clr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   wr_drop
);

    localparam int               NBYTES    = WIDTH / 8;
    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [SEL_W-1:0] SEL_DEPTH = SEL_W'(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_wr_drop;

    logic             w_busy;
    logic             w_sweep_we;
    logic [IDX_W-1:0] w_sweep_idx;
    logic [WIDTH-1:0] w_sweep_data;
    logic             w_in_hit;
    logic [IDX_W-1:0] w_in_idx;
    logic [WIDTH-1:0] w_in_old;
    logic [WIDTH-1:0] w_in_merged;
    logic             w_ext_we;

    register_sweep_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sweep (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr_req    (clr_req),
        .i_clr_data   (clr_data),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_idx  (w_sweep_idx),
        .o_sweep_data (w_sweep_data),
        .o_busy       (w_busy),
        .o_done       (done)
    );

    assign w_in_hit = (in_sel < SEL_DEPTH);
    assign w_in_idx = in_sel[IDX_W-1:0];
    assign w_ext_we = w_in_hit && (in_be != '0) && !w_busy;

    // Value the addressed register will hold after the edge (shared with bypass)
    always_comb begin
        w_in_old    = '0;
        w_in_merged = '0;
        if (w_in_hit) begin
            w_in_old = r_regs[w_in_idx];
        end else begin
            w_in_old = '0;
        end
        for (int b = 0; b < NBYTES; b++) begin
            w_in_merged[8*b +: 8] = byte_merge(w_in_old[8*b +: 8], in[8*b +: 8], in_be[b]);
        end
    end

    // Register array: sweep writes take priority, external writes only when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_sweep_we) begin
            r_regs[w_sweep_idx] <= w_sweep_data;
        end else if (w_ext_we) begin
            r_regs[w_in_idx] <= w_in_merged;
        end
    end

    // Flags an external write that lost to an active sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_busy && w_in_hit && (in_be != '0);
        end
    end

    assign busy    = w_busy;
    assign wr_drop = r_wr_drop;

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [SEL_W-1:0] w_sel;
        logic [WIDTH-1:0] w_rd;

        assign w_sel = out_sel[p*SEL_W +: SEL_W];

        // Out-of-range select reads as zero; bypass only for idle external writes
        always_comb begin
            w_rd = '0;
            if (w_sel >= SEL_DEPTH) begin
                w_rd = '0;
            end else if ((BYPASS != 0) && !w_busy && w_in_hit && (w_sel == in_sel)) begin
                w_rd = w_in_merged;
            end else begin
                w_rd = r_regs[w_sel[IDX_W-1:0]];
            end
        end

        assign out[p*WIDTH +: WIDTH] = w_rd;
    end

endmodule

// File: doc/general_register_file.md
# general_register_file

Parametrised successor to the general register bank: a WIDTH×DEPTH register file with one byte-enabled write port, NREAD independent combinational read ports, optional write-to-read bypass, and a hardware sweep sequencer that fills every register with a given value, one register per cycle. It sits in the datapath between the instruction decoder (select lines) and the ALU (operand buses and result bus). It keeps the bank's "out-of-range select means no register" convention.

## Interface
- WIDTH, 32: register width in bits; must be a multiple of 8.
- DEPTH, 28: number of registers, 2..2**SEL_W−1.
- SEL_W, 6: select width; any select ≥ DEPTH is "none".
- NREAD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a read of the register being written this cycle returns the merged write data; 0 = it returns the stored value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  WIDTH  write data.
- in_sel  in  SEL_W  write select; ≥ DEPTH means no write.
- in_be  in  WIDTH/8  byte enables; bit k covers in[8k+7:8k].
- out_sel  in  NREAD×SEL_W  packed read selects; port p uses slice p.
- out  out  NREAD×WIDTH  packed read data; port p uses slice p.
- clr_req  in  1  start-sweep request (level sampled at rising edge).
- clr_data  in  WIDTH  sweep fill value, captured with clr_req.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last sweep write.
- wr_drop  out  1  one-cycle pulse: an external write was discarded.

## Operation
- Reset (rst_n low, any time): all registers = 0; FSM = IDLE; sweep index = 0; busy = 0, done = 0, wr_drop = 0. Takes effect immediately, including mid-sweep; the sweep is abandoned.
- Write, IDLE only: at a rising edge with in_sel < DEPTH, register in_sel byte k ← in byte k where in_be[k]=1; other bytes keep their value. in_be = 0 is a legal no-op. in_sel ≥ DEPTH: no register changes.
- Read, per port, combinational: out_sel ≥ DEPTH → 0. Otherwise the stored value. If BYPASS=1, the FSM is IDLE, and out_sel == in_sel (< DEPTH), the port returns the byte-merged value the register will hold after the edge. Several ports may select the same register.
- FSM states:
  - IDLE: clr_req=1 at an edge → capture clr_data, index ← 0, go to SWEEP; busy rises the next cycle. An external write issued in that same edge still completes.
  - SWEEP: each edge writes register[index] ← captured value (all bytes) and increments index. The edge that writes index DEPTH−1 → DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy = 1 in SWEEP and DONE. clr_req while busy is ignored; it is not queued.
- A write while busy (in_sel < DEPTH and in_be ≠ 0) is discarded; wr_drop pulses in the following cycle. Reads during a sweep return stored contents; no bypass is applied to sweep writes.

## Timing
- Write latency: 1 edge. Read latency: 0, combinational from out_sel and stored state (plus in/in_sel/in_be when BYPASS=1).
- Sweep: clr_req edge → DEPTH write edges → done high for the cycle after the last write. Total busy time is DEPTH+1 cycles.
- Back-to-back sweeps: clr_req held high re-triggers on the first edge in IDLE after DONE.
- done and wr_drop are registered.

## Structure
- Shared package: FSM state enum (IDLE, SWEEP, DONE) and a byte-merge function (old, new, be → merged) used by both the write path and the bypass.
- One sub-module, register_sweep_ctrl: FSM, index counter, captured value, busy/done. It drives an internal write request that the top muxes ahead of the external port.
- Read ports are a generate loop over NREAD.

## Test plan
- Index fill: for i = 0..27, write 2**i with in_be=1111 → out port 0 with out_sel=i reads 2**i. Port 1 with out_sel=32 reads 0.
- Byte enable: reg 5 = 0x11223344; write 0xAABBCCDD with be=0101 → reg 5 = 0x11BB33DD.
- Bypass: reg 3 = 7; in_sel=3, in=8 with both out_sel=3, before the edge → out = 8 when BYPASS=1, 7 when BYPASS=0. After the edge both read 8.
- Sweep: clr_req with clr_data=0xDEADBEEF → busy for 29 cycles, a single done pulse, and all 28 registers read 0xDEADBEEF. A write to reg 2 mid-sweep → wr_drop pulse, and reg 2 = 0xDEADBEEF.
- Reset mid-sweep: rst_n low after 10 sweep writes → all registers 0, busy=0 immediately, and no done pulse.
- Ignored request: clr_req pulsed during SWEEP → exactly one done pulse and no second sweep.
